display_arbiter: RTL
====================

DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter DWELL, default 50_000_000, SHALL set the clock cycles one display channel is shown before rotating when both channels request.
REQ-002 Parameter ALERT_HOLD, default 100_000_000, SHALL set the minimum clock cycles an alert stays on the display once granted.
REQ-003 clk  input  1  system clock (50 MHz); the block SHALL use one clock only.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  3  level request per channel: bit0 alert, bit1/bit2 normal display channels.
REQ-006 val0, val1, val2  input  16 each  unsigned value offered by channel 0/1/2.
REQ-007 grant  output  3  registered one-hot grant, or 000 when idle.
REQ-008 disp_value  output  16  registered value for the 4-digit display, range 0..9999.
REQ-009 disp_blank  output  1  registered; 1 when no channel is granted.
REQ-010 clip  output  1  registered; 1 when the granted channel's value exceeds 9999.

Function
REQ-011 FSM states SHALL be IDLE, SHOW, ALERT; all outputs registered; inputs sampled at edge n SHALL take effect on outputs after edge n+1.
REQ-012 IDLE: grant=000, disp_blank=1, disp_value=0, clip=0.
REQ-013 IDLE -> ALERT when req[0]=1, with priority over req[1]/req[2].
REQ-014 IDLE -> SHOW when req[0]=0 and req[1] or req[2]=1; if both are set, the channel not equal to last_ch SHALL be granted.
REQ-015 last_ch (1 or 2) SHALL record the most recently granted normal channel; reset value 2, so channel 1 wins the first tie.
REQ-016 SHOW: dwell counter starts at 0 on entry or on a switch, incrementing each cycle.
REQ-017 SHOW: req[0]=1 SHALL preempt to ALERT on the next edge, regardless of the dwell count.
REQ-018 SHOW: if the granted channel's req drops, the grant SHALL move to the other normal channel if it requests, else to IDLE, on the next edge.
REQ-019 SHOW: when dwell count = DWELL-1 and the other normal channel requests, the grant SHALL switch to it and the count reset.
REQ-020 SHOW: if dwell count = DWELL-1 and the other channel is idle, the count SHALL reset and the grant stay.
REQ-021 ALERT: the hold counter starts at 0 on entry; the grant SHALL stay 001 while count < ALERT_HOLD-1 even if req[0] drops.
REQ-022 ALERT with count at ALERT_HOLD-1 or above (saturating) and req[0]=0 SHALL exit on the next edge.
REQ-023 The ALERT exit SHALL go to SHOW on last_ch if it requests, else the other normal channel, else IDLE; the dwell count restarts at 0.
REQ-024 ALERT with req[0] held high SHALL remain in ALERT indefinitely.
REQ-025 While granted, disp_value SHALL track the granted channel's val each cycle (one-cycle latency); a value above 9999 SHALL saturate to 9999 with clip=1.
REQ-026 Counters SHALL be sized by $clog2 of their parameter and SHALL never wrap.
REQ-027 grant SHALL never have more than one bit set.

Reset
REQ-028 While rst_n=0, the block SHALL force: state=IDLE, grant=000, disp_value=0, disp_blank=1, clip=0, last_ch=2, all counters=0.
REQ-029 A reset asserted mid-SHOW or mid-ALERT SHALL take effect immediately, with no pending grant carried over after release.

Verification (DWELL=4, ALERT_HOLD=6)
REQ-030 req=110, val1=12, val2=34 from IDLE -> grant 010 with disp_value 12 for 4 cycles, then 100 with 34 for 4 cycles, alternating.
REQ-031 SHOW ch1 with req[0] pulsed high for 1 cycle, val0=7777 -> grant 001 with disp_value 7777 for exactly 6 cycles, then back to 010.
REQ-032 req=010 with val1=12345 -> disp_value 9999, clip=1; then val1=42 -> disp_value 42, clip=0 one cycle later.
REQ-033 SHOW ch2, req[2] drops with req[1]=1 -> grant 010 on the next edge; both requests drop -> IDLE, disp_blank=1.
REQ-034 rst_n low during ALERT -> outputs reset immediately (grant 000, disp_blank 1); after release with req=100 -> grant 100.
REQ-035 req[0] held high for 20 cycles -> grant 001 for the whole interval plus 0 extra cycles once the hold count is already satisfied.

Source files
------------

// File: rtl/display_arbiter.sv
// Arbitrates a 4-digit display between one alert channel and two
// rotating normal channels, with saturation of values above 9999.
module display_arbiter #(
  parameter int unsigned DWELL      = 50_000_000,
  parameter int unsigned ALERT_HOLD = 100_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [15:0] val0,
  input  logic [15:0] val1,
  input  logic [15:0] val2,
  output logic [2:0]  grant,
  output logic [15:0] disp_value,
  output logic        disp_blank,
  output logic        clip
);

  localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned AH_W = (ALERT_HOLD > 1) ? $clog2(ALERT_HOLD) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [AH_W-1:0] HOLD_LAST  = AH_W'(ALERT_HOLD - 1);
  localparam logic [15:0]     DISP_MAX   = 16'd9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    ALERT = 2'd2
  } state_e;

  // Normal channel select: 0 = channel 1, 1 = channel 2.
  state_e          state_q, state_d;
  logic            cur_q, cur_d;
  logic            last_q, last_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [AH_W-1:0] hold_q, hold_d;

  logic [2:0]      grant_q, grant_d;
  logic [15:0]     value_q, value_d;
  logic            blank_q, blank_d;
  logic            clip_q, clip_d;

  logic            req_cur, req_oth, req_last, req_nlast;
  logic [15:0]     sel_val;

  assign req_cur   = cur_q  ? req[2] : req[1];
  assign req_oth   = cur_q  ? req[1] : req[2];
  assign req_last  = last_q ? req[2] : req[1];
  assign req_nlast = last_q ? req[1] : req[2];

  // State, channel bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= 1'b1;
      last_q  <= 1'b1;
      dwell_q <= '0;
      hold_q  <= '0;
      grant_q <= 3'b000;
      value_q <= 16'd0;
      blank_q <= 1'b1;
      clip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      value_q <= value_d;
      blank_q <= blank_d;
      clip_q  <= clip_d;
    end
  end

  // Next-state logic: alert priority, dwell rotation, alert minimum hold.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (req[0]) begin
          state_d = ALERT;
          hold_d  = '0;
        end else if (req[1] || req[2]) begin
          state_d = SHOW;
          cur_d   = (req[1] && req[2]) ? ~last_q : req[2];
          last_d  = (req[1] && req[2]) ? ~last_q : req[2];
          dwell_d = '0;
        end
      end
      SHOW: begin
        if (req[0]) begin
          state_d = ALERT;
          hold_d  = '0;
          dwell_d = '0;
        end else if (!req_cur) begin
          dwell_d = '0;
          if (req_oth) begin
            cur_d  = ~cur_q;
            last_d = ~cur_q;
          end else begin
            state_d = IDLE;
          end
        end else if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (req_oth) begin
            cur_d  = ~cur_q;
            last_d = ~cur_q;
          end
        end else begin
          dwell_d = dwell_q + DW_W'(1);
        end
      end
      ALERT: begin
        if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + AH_W'(1);
        end else if (!req[0]) begin
          hold_d  = '0;
          dwell_d = '0;
          if (req_last) begin
            state_d = SHOW;
            cur_d   = last_q;
          end else if (req_nlast) begin
            state_d = SHOW;
            cur_d   = ~last_q;
            last_d  = ~last_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        dwell_d = '0;
        hold_d  = '0;
      end
    endcase
  end

  // Output decode from the current state; value saturates at 9999.
  always_comb begin
    grant_d = 3'b000;
    value_d = 16'd0;
    blank_d = 1'b1;
    clip_d  = 1'b0;
    sel_val = 16'd0;
    unique case (state_q)
      SHOW: begin
        grant_d = cur_q ? 3'b100 : 3'b010;
        sel_val = cur_q ? val2 : val1;
        blank_d = 1'b0;
      end
      ALERT: begin
        grant_d = 3'b001;
        sel_val = val0;
        blank_d = 1'b0;
      end
      default: begin
        grant_d = 3'b000;
      end
    endcase
    if (!blank_d) begin
      if (sel_val > DISP_MAX) begin
        value_d = DISP_MAX;
        clip_d  = 1'b1;
      end else begin
        value_d = sel_val;
      end
    end
  end

  assign grant      = grant_q;
  assign disp_value = value_q;
  assign disp_blank = blank_q;
  assign clip       = clip_q;

endmodule
